// File: rtl/multi_lane_dispatcher.sv
// Multi-lane thread-ID dispatcher: walks the flat thread-ID range [0, max_tid]
// LANES IDs per beat and presents 3-D block coordinates for every lane,
// derived incrementally from a registered base coordinate (no divide/modulo).
module multi_lane_dispatcher #(
  parameter  int TOTAL_TID = 512,
  parameter  int LANES     = 4,
  localparam int W         = $clog2(TOTAL_TID)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clr,
  input  logic [W-1:0]       max_tid,
  input  logic [W-1:0]       ntid_x,
  input  logic [W-1:0]       ntid_y,
  input  logic [W-1:0]       ntid_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_tid_base,
  output logic [LANES-1:0]   lane_mask,
  output logic [LANES*W-1:0] tid_x,
  output logic [LANES*W-1:0] tid_y,
  output logic [LANES*W-1:0] tid_z,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;

  // Latched run configuration and walking position.
  logic [W-1:0]   cfg_max;
  logic [W-1:0]   cfg_nx;
  logic [W-1:0]   cfg_ny;
  logic [W-1:0]   cfg_nz;
  logic [W:0]     base;       // one extra bit so base never wraps at TOTAL_TID
  logic [W-1:0]   base_x;
  logic [W-1:0]   base_y;
  logic [W-1:0]   base_z;

  logic [3*W-1:0] walk;       // {z,y,x} scratch while chaining across lanes
  logic [3*W-1:0] next_coord; // coordinate following the top lane
  logic           fire;
  logic           last_beat;

  // Advance a {z,y,x} coordinate by one thread: x wraps into y, y into z.
  function automatic logic [3*W-1:0] step(
    input logic [3*W-1:0] c,
    input logic [W-1:0]   nx,
    input logic [W-1:0]   ny,
    input logic [W-1:0]   nz
  );
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    x = c[W-1:0];
    y = c[2*W-1:W];
    z = c[3*W-1:2*W];
    if (x == nx) begin
      x = {W{1'b0}};
      if (y == ny) begin
        y = {W{1'b0}};
        if (z == nz) begin
          z = {W{1'b0}};
        end else begin
          z = z + W'(1);
        end
      end else begin
        y = y + W'(1);
      end
    end else begin
      x = x + W'(1);
    end
    return {z, y, x};
  endfunction

  assign fire      = (state == RUN) && out_ready;
  assign last_beat = (base + (W+1)'(LANES - 1)) >= {1'b0, cfg_max};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: clr wins over everything, start only honoured outside RUN.
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = RUN;
          end else begin
            state_nx = state;
          end
        end
        RUN: begin
          if (out_ready && last_beat) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Config latch on launch, base position advance on every fired beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_max <= {W{1'b0}};
      cfg_nx  <= {W{1'b0}};
      cfg_ny  <= {W{1'b0}};
      cfg_nz  <= {W{1'b0}};
      base    <= {(W+1){1'b0}};
      base_x  <= {W{1'b0}};
      base_y  <= {W{1'b0}};
      base_z  <= {W{1'b0}};
    end else if (clr) begin
      base    <= base;
    end else if (start && (state != RUN)) begin
      cfg_max <= max_tid;
      cfg_nx  <= ntid_x;
      cfg_ny  <= ntid_y;
      cfg_nz  <= ntid_z;
      base    <= {(W+1){1'b0}};
      base_x  <= {W{1'b0}};
      base_y  <= {W{1'b0}};
      base_z  <= {W{1'b0}};
    end else if (fire) begin
      base    <= base + (W+1)'(LANES);
      base_x  <= next_coord[W-1:0];
      base_y  <= next_coord[2*W-1:W];
      base_z  <= next_coord[3*W-1:2*W];
    end
  end

  // Chain the lane coordinates from the base; masked lanes still get values.
  always_comb begin
    tid_x = {(LANES*W){1'b0}};
    tid_y = {(LANES*W){1'b0}};
    tid_z = {(LANES*W){1'b0}};
    walk  = {base_z, base_y, base_x};
    for (int i = 0; i < LANES; i++) begin
      tid_x[i*W +: W] = walk[W-1:0];
      tid_y[i*W +: W] = walk[2*W-1:W];
      tid_z[i*W +: W] = walk[3*W-1:2*W];
      walk = step(walk, cfg_nx, cfg_ny, cfg_nz);
    end
    next_coord = walk;
  end

  // Per-lane validity: lane carries a real thread only up to max_tid.
  always_comb begin
    lane_mask = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if ((state == RUN) && ((base + (W+1)'(i)) <= {1'b0, cfg_max})) begin
        lane_mask[i] = 1'b1;
      end else begin
        lane_mask[i] = 1'b0;
      end
    end
  end

  assign out_valid    = (state == RUN);
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign out_tid_base = base[W-1:0];

endmodule

// File: tb/tb_multi_lane_dispatcher.sv
// Randomised self-checking bench for multi_lane_dispatcher; expected beats are
// computed from flat thread IDs with plain division/modulo.
module tb_multi_lane_dispatcher;
  localparam int TT = 512;
  localparam int L  = 4;
  localparam int W  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // DUT A: four lanes
  logic           start = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [W-1:0]   max_tid = '0, ntid_x = '0, ntid_y = '0, ntid_z = '0;
  logic           out_valid, busy, done;
  logic [W-1:0]   out_tid_base;
  logic [L-1:0]   lane_mask;
  logic [L*W-1:0] tid_x, tid_y, tid_z;

  // DUT B: single lane
  logic           b_start = 1'b0, b_clr = 1'b0, b_ready = 1'b0;
  logic [W-1:0]   b_max = '0, b_nx = '0, b_ny = '0, b_nz = '0;
  logic           b_valid, b_busy, b_done;
  logic [W-1:0]   b_base;
  logic [0:0]     b_mask;
  logic [W-1:0]   b_x, b_y, b_z;

  multi_lane_dispatcher #(.TOTAL_TID(TT), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .max_tid(max_tid),
    .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_tid_base(out_tid_base),
    .lane_mask(lane_mask), .tid_x(tid_x), .tid_y(tid_y), .tid_z(tid_z),
    .busy(busy), .done(done));

  multi_lane_dispatcher #(.TOTAL_TID(TT), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .start(b_start), .clr(b_clr), .max_tid(b_max),
    .ntid_x(b_nx), .ntid_y(b_ny), .ntid_z(b_nz),
    .out_valid(b_valid), .out_ready(b_ready), .out_tid_base(b_base),
    .lane_mask(b_mask), .tid_x(b_x), .tid_y(b_y), .tid_z(b_z),
    .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Coordinate of flat thread t along one dimension.
  function automatic int coord_of(int t, int dim, int nx, int ny, int nz);
    case (dim)
      0:       return t % (nx + 1);
      1:       return (t / (nx + 1)) % (ny + 1);
      default: return (t / ((nx + 1) * (ny + 1))) % (nz + 1);
    endcase
  endfunction

  function automatic logic [63:0] model_coord(int beat, int n, int dim, int nx, int ny, int nz);
    logic [63:0] v;
    int c;
    v = '0;
    for (int i = 0; i < n; i++) begin
      c = coord_of(beat * n + i, dim, nx, ny, nz);
      v[i*W +: W] = c[W-1:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] model_mask(int beat, int n, int mx);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = ((beat * n + i) <= mx);
    return v;
  endfunction

  // One complete run on the four-lane DUT; mode 0 ready=1, 1 random, 2 pattern 1,0,0,1.
  task automatic run_case(input int mx, input int nx, input int ny, input int nz,
                          input int mode, input string name);
    int beats_exp, k, cyc, budget;
    bit r;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    beats_exp = (mx + 1 + L - 1) / L;
    budget    = beats_exp * 8 + 20;
    k = 0;
    cyc = 0;
    @(negedge clk);
    max_tid = W'(mx); ntid_x = W'(nx); ntid_y = W'(ny); ntid_z = W'(nz);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, "_first_valid"}, out_valid, 1);
    while (done !== 1'b1 && cyc < budget) begin
      if (out_valid !== 1'b1) begin
        check({name, "_valid_drop"}, out_valid, 1);
        break;
      end
      check({name, "_base"}, out_tid_base, k * L);
      check({name, "_mask"}, lane_mask, model_mask(k, L, mx));
      check({name, "_x"}, tid_x, model_coord(k, L, 0, nx, ny, nz));
      check({name, "_y"}, tid_y, model_coord(k, L, 1, nx, ny, nz));
      check({name, "_z"}, tid_z, model_coord(k, L, 2, nx, ny, nz));
      check({name, "_busy"}, busy, 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = pat[cyc % 4];
      endcase
      out_ready = r;
      // Disturb the config inputs and pulse start while running: both must be ignored.
      max_tid = W'($urandom); ntid_x = W'($urandom);
      ntid_y  = W'($urandom); ntid_z = W'($urandom);
      start   = ($urandom_range(0, 3) == 0);
      if (r) k++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_beats"}, k, beats_exp);
    check({name, "_done"}, done, 1);
    check({name, "_valid_after"}, out_valid, 0);
    check({name, "_mask_after"}, lane_mask, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check({name, "_done_hold"}, done, 1);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    int k1, cyc1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mask", lane_mask, 0);
    check("rst_base", out_tid_base, 0);
    check("rst_x", tid_x, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", out_valid, 0);

    run_case(7, 3, 1, 0, 0, "aligned");
    run_case(5, 7, 0, 0, 0, "partial");
    run_case(7, 1, 1, 1, 0, "wrap");
    run_case(7, 3, 1, 0, 2, "bp_pattern");
    run_case(41, 2, 3, 1, 2, "bp_long");
    run_case(0, 0, 0, 0, 1, "zero_dims");
    run_case(TT - 1, 7, 7, 7, 1, "full_range");
    for (int n = 0; n < 6; n++)
      run_case($urandom_range(0, 60), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 3), 1, "rand");

    // clr together with start mid-run returns to IDLE
    @(negedge clk);
    max_tid = W'(100); ntid_x = W'(3); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_pre_busy", busy, 1);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    @(negedge clk);
    check("clr_stay_idle", out_valid, 0);

    // rst mid-run abandons the run, restart uses new config from tid 0
    max_tid = W'(200); ntid_x = W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_mask", lane_mask, 0);
    check("arst_base", out_tid_base, 0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_busy", busy, 0);
    run_case(9, 2, 1, 1, 1, "after_rst");

    // single-lane full range: 512 beats
    @(negedge clk);
    b_max = W'(TT - 1); b_nx = W'(9); b_ny = W'(4); b_nz = W'(20);
    b_start = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k1 = 0; cyc1 = 0;
    while (b_done !== 1'b1 && cyc1 < 600) begin
      if (b_valid !== 1'b1) begin
        check("one_valid_drop", b_valid, 1);
        break;
      end
      check("one_base", b_base, k1);
      check("one_x", b_x, model_coord(k1, 1, 0, 9, 4, 20));
      check("one_z", b_z, model_coord(k1, 1, 2, 9, 4, 20));
      k1++;
      cyc1++;
      @(negedge clk);
    end
    check("one_beats", k1, TT);
    check("one_done", b_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_lane_dispatcher.md
MULTI_LANE_DISPATCHER -- requirements
Module: multi_lane_dispatcher

Interface
REQ-001 Parameters SHALL be:
- TOTAL_TID, default 512, thread-ID space size; W = $clog2(TOTAL_TID).
- LANES, default 4, thread IDs issued per beat; range 1..16.

REQ-002 Reset SHALL be one clock; reset is asynchronous and active-high.

REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  launch pulse; latches config.
- clr  in  1  synchronous abort / return to IDLE.
- max_tid  in  W  last thread ID, inclusive.
- ntid_x, ntid_y, ntid_z  in  W each  block dimension minus one.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_tid_base  out  W  flat ID of lane 0.
- lane_mask  out  LANES  per-lane valid.
- tid_x, tid_y, tid_z  out  LANES*W each  per-lane coordinates, lane i at bits [i*W +: W].
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.

REQ-005 In IDLE or DONE, start SHALL latch max_tid and ntid_x/y/z, zero the base counter and coordinates, and enter RUN the next cycle.

REQ-006 clr SHALL force IDLE from any state on the next edge, and SHALL win over start when both are asserted.

REQ-007 start asserted in RUN SHALL be ignored.

REQ-008 Latched config SHALL be used for the whole run; input changes during RUN SHALL have no effect.

REQ-009 out_valid SHALL be 1 exactly while in RUN.

REQ-010 A beat SHALL fire when out_valid && out_ready.

REQ-011 While out_valid=1 && out_ready=0, all beat outputs SHALL hold stable.

REQ-012 Lane coordinates SHALL be derived incrementally, with no divide or modulo:
- Lane 0 = registered base coordinates.
- Lane i = lane i-1 with x+1; x wraps ntid_x->0 and carries into y; y wraps ntid_y->0 and carries into z; z wraps ntid_z->0.

REQ-013 On each fire:
- Base flat counter += LANES.
- Base coordinates <= lane LANES-1 coordinates advanced by one step, using the REQ-012 rule.

REQ-014 The base flat counter SHALL be W+1 bits so that max_tid = TOTAL_TID-1 cannot overflow.

REQ-015 lane_mask[i] SHALL be 1 iff out_valid && (base + i) <= max_tid, compared at W+1 bits.

REQ-016 The last beat is the one where base + LANES - 1 >= max_tid. When it fires, the FSM SHALL enter DONE.

REQ-017 Latency and throughput:
- First beat: out_valid on the cycle after start is sampled.
- One beat per cycle under continuous out_ready.
- Total beats = ceil((max_tid+1)/LANES).

REQ-018 In DONE, done SHALL stay 1 and out_valid SHALL stay 0 until clr or start.

REQ-019 Masked-off lanes SHALL still present their computed coordinates; consumers ignore them.

REQ-020 ntid_x = ntid_y = ntid_z = 0 SHALL be legal. All lanes then show coordinate (0,0,0).

Reset
REQ-021 While rst is asserted (asynchronously):
- State = IDLE.
- out_valid, busy, done, lane_mask = 0.
- Base counter, coordinates and latched config = 0.

REQ-022 rst asserted mid-RUN SHALL abandon the run with no further beat. A subsequent start SHALL begin again from tid 0.

Verification
REQ-023 Full, aligned run: LANES=4, max_tid=7, ntid_x=3, ntid_y=1, ntid_z=0, out_ready=1 ->
- Beat 1: base 0, x={0,1,2,3}, y={0,0,0,0}.
- Beat 2: base 4, x={0,1,2,3}, y={1,1,1,1}.
- Then done=1.

REQ-024 Partial last beat: LANES=4, max_tid=5, ntid_x=7 ->
- Beat 2 has lane_mask=4'b0011, x={4,5,6,7}.
- Exactly 2 beats.

REQ-025 Backpressure: out_ready toggled 1,0,0,1 ->
- Outputs are held through the stall cycles.
- No beat is skipped or duplicated; beat count is unchanged.

REQ-026 Wrap across dimensions: LANES=4, ntid_x=1, ntid_y=1, ntid_z=1, max_tid=7 ->
- Beat 1: (x,y,z) = (0,0,0), (1,0,0), (0,1,0), (1,1,0).
- Beat 2: same four with z=1.

REQ-027 clr and start on the same cycle mid-run -> IDLE, out_valid=0 the next cycle.

REQ-028 rst mid-run followed by start with a new max_tid -> dispatch restarts at base 0 using the new config.

REQ-029 Single-lane corner: LANES=1, TOTAL_TID=512, max_tid=511 -> 512 beats, with no overflow of the W+1-bit base counter.
